// File: rtl/pellet_tracker.sv
// Pellet map bookkeeping: holds dot/power-pellet maps, clears cells as Pac-Man eats,
// tracks remaining pellets and a saturating score, and flags level completion.
module pellet_tracker #(
    parameter int                     COLS     = 18,
    parameter int                     ROWS     = 5,
    parameter int                     XW       = 5,
    parameter int                     YW       = 5,
    parameter logic [ROWS*COLS-1:0]   DOT_INIT = '0,
    parameter logic [ROWS*COLS-1:0]   PWR_INIT = '0,
    parameter int                     DOT_PTS  = 10,
    parameter int                     PWR_PTS  = 50,
    parameter int                     SCORE_W  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       scene,
    input  logic                             eat_tick,
    input  logic [XW-1:0]                    pac_x,
    input  logic [YW-1:0]                    pac_y,
    output logic [ROWS*COLS-1:0]             dot_map,
    output logic [ROWS*COLS-1:0]             pwr_map,
    output logic [$clog2(ROWS*COLS+1)-1:0]   pellet_cnt,
    output logic [SCORE_W-1:0]               score,
    output logic                             dot_eaten,
    output logic                             pwr_eaten,
    output logic                             all_clear
);
    localparam int NC = ROWS * COLS;
    localparam int CW = $clog2(NC + 1);
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    function automatic int popcnt(input logic [NC-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NC; i++) c += int'(v[i]);
        return c;
    endfunction

    localparam logic [CW-1:0] INIT_CNT = CW'(popcnt(DOT_INIT | PWR_INIT));

    typedef enum logic [1:0] {IDLE, LOADED, PLAY, DONE} state_t;
    state_t state;

    logic                    in_range;
    logic [IW-1:0]           idx;
    logic                    pwr_hit, dot_hit, eat_ok;
    logic [SCORE_W+31:0]     pts_sum;
    logic [SCORE_W-1:0]      score_next;

    always_comb begin
        in_range = (int'(pac_x) < COLS) && (int'(pac_y) < ROWS);
        idx      = IW'(int'(pac_x) + int'(pac_y) * COLS);
        pwr_hit  = in_range && pwr_map[idx];
        dot_hit  = in_range && dot_map[idx];
        eat_ok   = (scene == 2'b01) && eat_tick && (pwr_hit || dot_hit);
        // Power pellet takes precedence; the maps are disjoint anyway.
        pts_sum  = {32'd0, score} + (SCORE_W+32)'(pwr_hit ? PWR_PTS : DOT_PTS);
        score_next = (pts_sum > {32'd0, SCORE_MAX}) ? SCORE_MAX : pts_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dot_map    <= '0;
            pwr_map    <= '0;
            pellet_cnt <= '0;
            score      <= '0;
            dot_eaten  <= 1'b0;
            pwr_eaten  <= 1'b0;
            all_clear  <= 1'b0;
        end else begin
            dot_eaten <= 1'b0;
            pwr_eaten <= 1'b0;
            if (scene == 2'b00) begin
                // Reload beats everything, including a same-cycle eat.
                state      <= LOADED;
                dot_map    <= DOT_INIT;
                pwr_map    <= PWR_INIT;
                pellet_cnt <= INIT_CNT;
                score      <= '0;
                all_clear  <= 1'b0;
            end else begin
                case (state)
                    LOADED: if (scene == 2'b01) state <= PLAY;
                    PLAY: begin
                        if (pellet_cnt == '0) begin
                            state     <= DONE;
                            all_clear <= 1'b1;
                        end else if (eat_ok) begin
                            if (pwr_hit) begin
                                pwr_map[idx] <= 1'b0;
                                pwr_eaten    <= 1'b1;
                            end else begin
                                dot_map[idx] <= 1'b0;
                                dot_eaten    <= 1'b1;
                            end
                            pellet_cnt <= pellet_cnt - CW'(1);
                            score      <= score_next;
                            if (pellet_cnt == CW'(1)) begin
                                state     <= DONE;
                                all_clear <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pellet_tracker.sv
// Randomized bench for pellet_tracker against a cell-map reference model, plus a
// narrow-score instance for saturation.
module tb_pellet_tracker;
    localparam int COLS = 18, ROWS = 5, NC = 90;

    function automatic logic [NC-1:0] mk_pwr();
        logic [NC-1:0] v;
        v = '0;
        v[18] = 1'b1; v[40] = 1'b1; v[71] = 1'b1;
        return v;
    endfunction

    function automatic logic [NC-1:0] mk_dot();
        logic [NC-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++)
            if ((i % 3 == 0 || i % 7 == 1) && i != 18 && i != 40 && i != 71) v[i] = 1'b1;
        return v;
    endfunction

    localparam logic [NC-1:0] DI = mk_dot();
    localparam logic [NC-1:0] PI = mk_pwr();

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] scene = 2'b10;
    logic eat_tick = 1'b0;
    logic [4:0] pac_x = '0, pac_y = '0;
    logic [NC-1:0] dot_map, pwr_map;
    logic [6:0] pellet_cnt;
    logic [15:0] score;
    logic dot_eaten, pwr_eaten, all_clear;

    logic [1:0] s_scene = 2'b10;
    logic s_tick = 1'b0;
    logic [2:0] s_x = '0;
    logic [1:0] s_y = '0;
    logic [7:0] s_dot, s_pwr;
    logic [3:0] s_cnt;
    logic [5:0] s_score;
    logic s_de, s_pe, s_ac;

    always #5 clk = ~clk;

    pellet_tracker #(.DOT_INIT(DI), .PWR_INIT(PI)) dut (
        .clk(clk), .rst_n(rst_n), .scene(scene), .eat_tick(eat_tick),
        .pac_x(pac_x), .pac_y(pac_y), .dot_map(dot_map), .pwr_map(pwr_map),
        .pellet_cnt(pellet_cnt), .score(score), .dot_eaten(dot_eaten),
        .pwr_eaten(pwr_eaten), .all_clear(all_clear));

    pellet_tracker #(.COLS(4), .ROWS(2), .XW(3), .YW(2), .DOT_INIT(8'hFF),
                     .PWR_INIT(8'h00), .SCORE_W(6)) dut_s (
        .clk(clk), .rst_n(rst_n), .scene(s_scene), .eat_tick(s_tick),
        .pac_x(s_x), .pac_y(s_y), .dot_map(s_dot), .pwr_map(s_pwr),
        .pellet_cnt(s_cnt), .score(s_score), .dot_eaten(s_de),
        .pwr_eaten(s_pe), .all_clear(s_ac));

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 loaded, 2 play, 3 done; count derived from maps.
    logic [NC-1:0] m_dot = '0, m_pwr = '0;
    int m_phase = 0, m_score = 0;
    bit m_de = 0, m_pe = 0, m_ac = 0;

    function automatic int m_cnt();
        return $countones(m_dot | m_pwr);
    endfunction

    task automatic model_reset();
        m_dot = '0; m_pwr = '0; m_phase = 0; m_score = 0;
        m_de = 0; m_pe = 0; m_ac = 0;
    endtask

    task automatic model_step(input int sc, input bit tk, input int x, input int y);
        int i;
        m_de = 0; m_pe = 0;
        if (sc == 0) begin
            m_phase = 1; m_dot = DI; m_pwr = PI; m_score = 0; m_ac = 0;
        end else if (m_phase == 1) begin
            if (sc == 1) m_phase = 2;
        end else if (m_phase == 2) begin
            if (m_cnt() == 0) begin
                m_phase = 3; m_ac = 1;
            end else if (sc == 1 && tk && x < COLS && y < ROWS) begin
                i = x + y * COLS;
                if (m_pwr[i]) begin
                    m_pwr[i] = 1'b0; m_pe = 1;
                    m_score = (m_score + 50 > 65535) ? 65535 : m_score + 50;
                end else if (m_dot[i]) begin
                    m_dot[i] = 1'b0; m_de = 1;
                    m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
                end
                if (m_cnt() == 0) begin
                    m_phase = 3; m_ac = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".dot_map"}, dot_map, m_dot);
        chk({t, ".pwr_map"}, pwr_map, m_pwr);
        chk({t, ".cnt"}, pellet_cnt, m_cnt());
        chk({t, ".score"}, score, m_score);
        chk({t, ".dot_eaten"}, dot_eaten, m_de);
        chk({t, ".pwr_eaten"}, pwr_eaten, m_pe);
        chk({t, ".all_clear"}, all_clear, m_ac);
    endtask

    task automatic step(input string t, input int sc, input bit tk, input int x, input int y);
        scene = sc[1:0]; eat_tick = tk; pac_x = x[4:0]; pac_y = y[4:0];
        @(posedge clk); #1;
        model_step(sc, tk, x, y);
        check_all(t);
    endtask

    initial begin
        int r, sc;
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        rst_n = 1'b1;
        step("idle_hold", 2, 1, 3, 0);
        step("load", 0, 0, 0, 0);
        chk("load_cnt_abs", pellet_cnt, $countones(DI | PI));
        step("loaded_tick_ignored", 1, 1, 3, 0);
        step("eat_dot3", 1, 1, 3, 0);
        chk("dot3_score", score, 10);
        chk("dot3_pulse", dot_eaten, 1);
        step("dot_pulse_drop", 1, 0, 0, 0);
        step("eat_pwr18", 1, 1, 0, 1);
        chk("pwr18_score", score, 60);
        step("pwr18_again", 1, 1, 0, 1);
        chk("pwr18_again_pulse", pwr_eaten, 0);
        step("x_out_of_range", 1, 1, 20, 0);
        step("y_out_of_range", 1, 1, 2, 5);
        step("hold_win", 2, 1, 6, 0);
        step("hold_lose", 3, 1, 9, 0);

        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            sc = (r < 2) ? 0 : (r < 8) ? (2 + (r & 1)) : 1;
            step("rand", sc, 1'($urandom_range(0, 1)), $urandom_range(0, 21), $urandom_range(0, 6));
        end

        // Asynchronous reset in the middle of a cycle.
        step("pre_rst_load", 0, 0, 0, 0);
        step("pre_rst_play", 1, 1, 3, 0);
        step("pre_rst_eat", 1, 1, 3, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        step("post_rst_idle", 1, 1, 6, 0);

        step("all_load", 0, 0, 0, 0);
        step("all_play", 1, 0, 0, 0);
        for (int i = 0; i < NC; i++) step("eat_all", 1, 1, i % COLS, i / COLS);
        chk("all_clear_set", all_clear, 1);
        chk("all_cnt_zero", pellet_cnt, 0);
        step("done_hold", 1, 1, 3, 0);
        step("reload_vs_tick", 0, 1, 3, 0);
        chk("reload_clears_ac", all_clear, 0);

        // Narrow-score instance: 7 dots of 10 saturate at 63.
        s_scene = 2'b00; step("s_bg", 2, 0, 0, 0);
        s_scene = 2'b01; step("s_bg", 2, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            s_tick = 1'b1; s_x = 3'(k % 4); s_y = 2'(k / 4);
            step("s_bg", 2, 0, 0, 0);
            chk("s_score", s_score, (10 * (k + 1) > 63) ? 63 : 10 * (k + 1));
            chk("s_dot_pulse", s_de, 1);
            chk("s_cnt", s_cnt, 7 - k);
        end
        chk("s_all_clear", s_ac, 1);
        s_tick = 1'b0;
        step("s_bg", 2, 0, 0, 0);
        chk("s_score_hold", s_score, 63);
        chk("s_pulse_drop", s_de, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
